tt_um_fountaincoder_top_v2: RTL and testbench



---
 rtl/tt_um_fountaincoder_top_v2.sv | 120 ++++++++++++
 tb/tb_tt_um_fountaincoder_top_v2.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tt_um_fountaincoder_top_v2.sv
// Tiny Tapeout MADD engine: byte-loaded 8x8 unsigned multiply-accumulate into a
// 24-bit wrapping accumulator, commanded by a strobed opcode on uio_in.
module tt_um_fountaincoder_top_v2 #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_LD_A   = 3'd1,
        OP_LD_B   = 3'd2,
        OP_MUL    = 3'd3,
        OP_MADD   = 3'd4,
        OP_CLR    = 3'd5,
        OP_SEL    = 3'd6,
        OP_MADD_D = 3'd7
    } opcode_e;

    logic [7:0]       a_q, a_d, b_q, b_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]       sel_q, sel_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             stb_q;

    opcode_e          op;
    logic             fire;
    logic [7:0]       mul_b;
    logic [15:0]      product;
    logic [ACC_W:0]   sum;
    logic             unused_uio;

    assign op         = opcode_e'(uio_in[2:0]);
    assign fire       = uio_in[3] & ~stb_q & ena;
    assign unused_uio = &{1'b0, uio_in[7:4]};

    // MADD_D multiplies by the live data byte instead of the stored B operand.
    assign mul_b   = (op == OP_MADD_D) ? ui_in : b_q;
    assign product = a_q * mul_b;
    assign sum     = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, product};

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        sel_d = sel_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        ack_d = ack_q;
        if (fire) begin
            ack_d = ~ack_q;
            unique case (op)
                OP_NOP:  ;
                OP_LD_A: a_d = ui_in;
                OP_LD_B: b_d = ui_in;
                OP_MUL:  acc_d = {{(ACC_W - 16){1'b0}}, product};
                OP_MADD, OP_MADD_D: begin
                    acc_d = sum[ACC_W-1:0];
                    ovf_d = ovf_q | sum[ACC_W];
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
                OP_CLR: begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = '0;
                end
                OP_SEL:  sel_d = ui_in[1:0];
                default: ;
            endcase
        end
    end

    // The harness pin keeps its name but is used as an active-high reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            sel_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
            ack_q <= 1'b0;
            stb_q <= 1'b0;
        end else begin
            stb_q <= uio_in[3];
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            sel_q <= sel_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            ack_q <= ack_d;
        end
    end

    always_comb begin
        uo_out = '0;
        unique case (sel_q)
            2'd0: uo_out = acc_q[7:0];
            2'd1: uo_out = acc_q[15:8];
            2'd2: uo_out = acc_q[23:16];
            2'd3: uo_out = {ovf_q, cnt_q};
            default: uo_out = '0;
        endcase
    end

    assign uio_out = {1'b0, ack_q, (acc_q == '0), ovf_q, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_fountaincoder_top_v2.sv
// Directed bench for the MADD engine: a command vector table followed by
// hand-written sequences for overflow, held strobe, enable gating and reset.
module tb_tt_um_fountaincoder_top_v2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;
    logic exp_ack = 1'b0;

    tt_um_fountaincoder_top_v2 #(.ACC_W(24), .CNT_W(7)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
        string      name;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
        end
    endtask

    // Expected uio_out built from independently tracked ack plus given zero/ovf.
    function automatic logic [7:0] uio_exp(input logic zero, input logic ovf);
        return {1'b0, exp_ack, zero, ovf, 4'b0000};
    endfunction

    task automatic cmd(input logic [2:0] op, input logic [7:0] data);
        @(negedge clk);
        ui_in  = data;
        uio_in = {4'b0000, 1'b1, op};
        @(negedge clk);
        uio_in[3] = 1'b0;
        exp_ack   = ~exp_ack;
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #1;
        chk("reset_uo", uo_out, 8'h00);
        chk("reset_uio", uio_out, 8'h20);
        chk("reset_oe", uio_oe, 8'hF0);
        @(negedge clk);
        rst_n = 1'b0;

        vecs[0] = '{3'd1, 8'd12,  8'h00, 8'h60, "ld_a12"};
        vecs[1] = '{3'd2, 8'd13,  8'h00, 8'h20, "ld_b13"};
        vecs[2] = '{3'd3, 8'h00,  8'h9C, 8'h40, "mul"};
        vecs[3] = '{3'd6, 8'h01,  8'h00, 8'h00, "sel1"};
        vecs[4] = '{3'd6, 8'h03,  8'h00, 8'h40, "sel3"};
        vecs[5] = '{3'd4, 8'h00,  8'h01, 8'h00, "madd_cnt1"};
        vecs[6] = '{3'd6, 8'h01,  8'h01, 8'h40, "sel1_acc138"};
        vecs[7] = '{3'd0, 8'hAA,  8'h01, 8'h00, "nop"};
        vecs[8] = '{3'd5, 8'h00,  8'h00, 8'h60, "clr"};
        vecs[9] = '{3'd6, 8'hFC,  8'h00, 8'h20, "sel0"};

        for (int i = 0; i < 10; i++) begin
            cmd(vecs[i].op, vecs[i].data);
            chk({vecs[i].name, "_uo"}, uo_out, vecs[i].exp_uo);
            chk({vecs[i].name, "_uio"}, uio_out, vecs[i].exp_uio);
        end

        // Overflow: 259 * 65025 = 0x1_00FB03, wraps to 0x00FB03
        cmd(3'd5, 8'h00);
        cmd(3'd1, 8'hFF);
        cmd(3'd2, 8'hFF);
        for (int i = 0; i < 259; i++) cmd(3'd4, 8'h00);
        chk("ovf_b0", uo_out, 8'h03);
        chk("ovf_uio", uio_out, uio_exp(1'b0, 1'b1));
        cmd(3'd6, 8'h01);
        chk("ovf_b1", uo_out, 8'hFB);
        cmd(3'd6, 8'h02);
        chk("ovf_b2", uo_out, 8'h00);
        cmd(3'd6, 8'h03);
        chk("ovf_stat", uo_out, 8'hFF);
        chk("ovf_stat_uio", uio_out, uio_exp(1'b0, 1'b1));

        // Strobe held high for 10 cycles executes once
        cmd(3'd5, 8'h00);
        cmd(3'd6, 8'h00);
        cmd(3'd1, 8'd2);
        cmd(3'd2, 8'd3);
        @(negedge clk);
        uio_in = {4'b0000, 1'b1, 3'd4};
        repeat (10) @(negedge clk);
        uio_in[3] = 1'b0;
        exp_ack   = ~exp_ack;
        @(negedge clk);
        chk("hold_acc", uo_out, 8'h06);
        chk("hold_uio", uio_out, uio_exp(1'b0, 1'b0));

        // Strobe edge while disabled is lost
        ena    = 1'b0;
        uio_in = {4'b0000, 1'b1, 3'd4};
        repeat (2) @(negedge clk);
        uio_in[3] = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        chk("ena0_acc", uo_out, 8'h06);
        chk("ena0_uio", uio_out, uio_exp(1'b0, 1'b0));

        // MADD_D uses ui_in as multiplier and leaves B (=3) alone
        cmd(3'd5, 8'h00);
        cmd(3'd1, 8'd16);
        cmd(3'd7, 8'd16);
        chk("maddd_b0", uo_out, 8'h00);
        cmd(3'd6, 8'h01);
        chk("maddd_b1", uo_out, 8'h01);
        cmd(3'd3, 8'h00);
        chk("mul_after_b1", uo_out, 8'h00);
        cmd(3'd6, 8'h00);
        chk("mul_after_b0", uo_out, 8'h30);
        chk("mul_after_uio", uio_out, uio_exp(1'b0, 1'b0));

        // Async reset between edges with a command pending
        @(negedge clk);
        uio_in = {4'b0000, 1'b1, 3'd3};
        #2 rst_n = 1'b1;
        #1;
        chk("areset_uo", uo_out, 8'h00);
        chk("areset_uio", uio_out, 8'h20);
        chk("areset_oe", uio_oe, 8'hF0);
        @(negedge clk);
        uio_in[3] = 1'b0;
        @(negedge clk);
        rst_n   = 1'b0;
        exp_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_uo", uo_out, 8'h00);
        chk("post_reset_uio", uio_out, uio_exp(1'b1, 1'b0));
        cmd(3'd3, 8'h00);
        chk("post_reset_mul", uo_out, 8'h00);
        chk("post_reset_mul_uio", uio_out, uio_exp(1'b1, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
